status_transmitter: RTL and testbench



---
 rtl/status_transmitter.sv | 112 +++++++++++
 tb/tb_status_transmitter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/status_transmitter.sv
// Phase-readback frame builder: sync 0xA5, status, NUM_CHANNELS phases, XOR checksum into the TX FIFO.
// Latency: first byte presented the cycle after req is accepted; one byte per cycle when unstalled.
// Backpressure: txfifo_full holds state, idx and csum, and the same byte is re-presented until written.
module status_transmitter #(
  parameter int NUM_CHANNELS = 256,
  parameter int DATA_W       = 8,
  parameter int PHASE_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic                            read_error,
  // Channel i occupies phases[i*PHASE_W +: PHASE_W].
  input  logic [NUM_CHANNELS*PHASE_W-1:0] phases,
  output logic                            busy,
  output logic                            done,
  input  logic                            txfifo_full,
  output logic                            txfifo_wr,
  output logic [DATA_W-1:0]               txfifo_data
);

  localparam int                IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(8'hA5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_STAT,
    S_PHASE,
    S_CSUM,
    S_FIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] status_q;
  logic [PHASE_W-1:0] cur_phase;
  logic              send_st;

  // Live phase of the channel currently being sent; sampled at the write cycle.
  always_comb begin
    cur_phase = phases[int'(idx)*PHASE_W +: PHASE_W];
  end

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: send states advance only on an actual write.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_HDR;
      S_HDR:   if (txfifo_wr) state_nxt = S_STAT;
      S_STAT:  if (txfifo_wr) state_nxt = S_PHASE;
      S_PHASE: if (txfifo_wr && (idx == LAST_IDX)) state_nxt = S_CSUM;
      S_CSUM:  if (txfifo_wr) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: write strobe and byte mux are pure functions of state and full.
  always_comb begin
    send_st     = (state == S_HDR) || (state == S_STAT) ||
                  (state == S_PHASE) || (state == S_CSUM);
    busy        = send_st;
    done        = (state == S_FIN);
    txfifo_wr   = send_st && !txfifo_full;
    txfifo_data = '0;
    case (state)
      S_HDR:   txfifo_data = SYNC_BYTE;
      S_STAT:  txfifo_data = status_q;
      S_PHASE: txfifo_data[PHASE_W-1:0] = cur_phase;
      S_CSUM:  txfifo_data = csum;
      default: txfifo_data = '0;
    endcase
  end

  // Frame datapath: latch status on accept, then fold each written byte into csum and step idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      csum     <= '0;
      status_q <= '0;
    end else if (state == S_IDLE) begin
      if (req) begin
        status_q <= DATA_W'(read_error);
        idx      <= '0;
        csum     <= '0;
      end
    end else if (txfifo_wr) begin
      // The checksum byte itself is not part of the checksum.
      if (state != S_CSUM) begin
        csum <= csum ^ txfifo_data;
      end
      // idx parks on the last channel rather than wrapping.
      if ((state == S_PHASE) && (idx != LAST_IDX)) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_status_transmitter.sv
// Directed bench for status_transmitter: a 4-channel and a 256-channel instance share clk/rst/full.
// Expected bytes are queued when a request is driven and popped on every observed FIFO write.
// Per-cycle write/busy/done activity is collected into bit masks and compared after each scenario.
module tb_status_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req4;
  logic          req256;
  logic          read_error;
  logic          txfifo_full;
  logic [31:0]   ph4;
  logic [2047:0] ph256;

  logic          busy4, done4, wr4;
  logic [7:0]    data4;
  logic          busy256, done256, wr256;
  logic [7:0]    data256;

  status_transmitter #(.NUM_CHANNELS(4), .DATA_W(8), .PHASE_W(8)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .read_error(read_error), .phases(ph4),
    .busy(busy4), .done(done4), .txfifo_full(txfifo_full),
    .txfifo_wr(wr4), .txfifo_data(data4)
  );

  status_transmitter #(.NUM_CHANNELS(256), .DATA_W(8), .PHASE_W(8)) dut256 (
    .clk(clk), .rst(rst), .req(req256), .read_error(read_error), .phases(ph256),
    .busy(busy256), .done(done256), .txfifo_full(txfifo_full),
    .txfifo_wr(wr256), .txfifo_data(data256)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  sb[$];
  bit          sel256;
  int          cnum;
  logic [63:0] wr_mask, done_mask, busy_mask;
  int          n_wr, first_wr, last_wr, done_cyc;
  logic [7:0]  hold_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_scn(input bit big);
    sel256    = big;
    cnum      = -1;
    wr_mask   = '0;
    done_mask = '0;
    busy_mask = '0;
    n_wr      = 0;
    first_wr  = -1;
    last_wr   = -1;
    done_cyc  = -1;
  endtask

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[i]) sb.push_back(b[i]);
  endtask

  // One clock cycle: drive inputs, let comb outputs settle, monitor, then cross the edge.
  task automatic cyc(input logic full, input logic rq, input logic rs);
    logic       b, d, w;
    logic [7:0] dat;
    logic [7:0] e;
    txfifo_full = full;
    rst         = rs;
    if (sel256) req256 = rq; else req4 = rq;
    #1;
    cnum++;
    b   = sel256 ? busy256 : busy4;
    d   = sel256 ? done256 : done4;
    w   = sel256 ? wr256   : wr4;
    dat = sel256 ? data256 : data4;
    if (w === 1'b1) begin
      n_wr++;
      if (first_wr < 0) first_wr = cnum;
      last_wr = cnum;
      if (cnum >= 0 && cnum < 64) wr_mask[cnum] = 1'b1;
      if (sb.size() == 0) begin
        chk("write_without_expected_byte", {31'b0, w}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tx_byte", {24'b0, dat}, {24'b0, e});
      end
    end
    if (d === 1'b1) begin
      done_cyc = cnum;
      if (cnum >= 0 && cnum < 64) done_mask[cnum] = 1'b1;
    end
    if (b === 1'b1 && cnum >= 0 && cnum < 64) busy_mask[cnum] = 1'b1;
    if (full && b === 1'b1 && !sel256) chk("stall_hold_byte", {24'b0, dat}, {24'b0, hold_exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fr[$];
    rst = 1'b1; req4 = 1'b0; req256 = 1'b0; read_error = 1'b0; txfifo_full = 1'b0;
    ph4 = {8'h40, 8'h30, 8'h20, 8'h10};
    for (int i = 0; i < 256; i++) ph256[i*8 +: 8] = 8'(i);
    hold_exp = 8'h10;
    sel256 = 1'b0;
    cnum = -1;
    @(posedge clk);
    #1;

    // Reset held with req high: must stay idle with zeroed outputs.
    begin_scn(0);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    chk("rst_busy", {31'b0, busy4}, 32'd0);
    chk("rst_done", {31'b0, done4}, 32'd0);
    chk("rst_wr", {31'b0, wr4}, 32'd0);
    chk("rst_data", {24'b0, data4}, 32'd0);
    chk("rst_busy256", {31'b0, busy256}, 32'd0);
    cyc(0, 0, 0);
    chk("idle_no_activity", wr_mask[31:0] | busy_mask[31:0], 32'd0);

    // Basic frame.
    begin_scn(0);
    fr = '{8'hA5, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hE5};
    push_bytes(fr);
    cyc(0, 1, 0);
    for (int c = 1; c <= 9; c++) cyc(0, 0, 0);
    chk("basic_wr_cycles", wr_mask[31:0], 32'h0000_00FE);
    chk("basic_done_cycle", done_mask[31:0], 32'h0000_0100);
    chk("basic_busy_cycles", busy_mask[31:0], 32'h0000_00FE);
    chk("basic_sb_empty", sb.size(), 32'd0);

    // Backpressure in cycles 3..5.
    begin_scn(0);
    push_bytes(fr);
    cyc(0, 1, 0);
    for (int c = 1; c <= 12; c++) cyc((c >= 3 && c <= 5), 0, 0);
    chk("bp_wr_cycles", wr_mask[31:0], 32'h0000_07C6);
    chk("bp_done_cycle", done_mask[31:0], 32'h0000_0800);
    chk("bp_busy_cycles", busy_mask[31:0], 32'h0000_07FE);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Error status latched at accept, dropped mid-frame.
    begin_scn(0);
    fr = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'hE4};
    push_bytes(fr);
    read_error = 1'b1;
    cyc(0, 1, 0);
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) read_error = 1'b0;
      cyc(0, 0, 0);
    end
    chk("err_wr_cycles", wr_mask[31:0], 32'h0000_00FE);
    chk("err_done_cycle", done_mask[31:0], 32'h0000_0100);
    chk("err_sb_empty", sb.size(), 32'd0);

    // Held request back-to-back, plus pulses mid-frame and in FIN that must be ignored.
    begin_scn(0);
    fr = '{8'hA5, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hE5};
    push_bytes(fr);
    push_bytes(fr);
    cyc(0, 1, 0);
    for (int c = 1; c <= 20; c++) cyc(0, (c <= 9) || (c == 12) || (c == 17), 0);
    chk("held_wr_cycles", wr_mask[31:0], 32'h0001_FCFE);
    chk("held_done_cycles", done_mask[31:0], 32'h0002_0100);
    chk("held_busy_cycles", busy_mask[31:0], 32'h0001_FCFE);
    chk("held_sb_empty", sb.size(), 32'd0);

    // Reset during the third byte: frame abandoned, then a clean frame.
    begin_scn(0);
    fr = '{8'hA5, 8'h00, 8'h10};
    push_bytes(fr);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    for (int c = 4; c <= 8; c++) cyc(0, 0, 0);
    chk("rstmid_wr_cycles", wr_mask[31:0], 32'h0000_000E);
    chk("rstmid_busy_cycles", busy_mask[31:0], 32'h0000_000E);
    chk("rstmid_no_done", done_mask[31:0], 32'd0);
    chk("rstmid_sb_empty", sb.size(), 32'd0);
    begin_scn(0);
    fr = '{8'hA5, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hE5};
    push_bytes(fr);
    cyc(0, 1, 0);
    for (int c = 1; c <= 9; c++) cyc(0, 0, 0);
    chk("rstnew_wr_cycles", wr_mask[31:0], 32'h0000_00FE);
    chk("rstnew_done_cycle", done_mask[31:0], 32'h0000_0100);
    chk("rstnew_sb_empty", sb.size(), 32'd0);

    // Full-size 256-channel frame, phases[i] = i.
    begin_scn(1);
    sb.push_back(8'hA5);
    sb.push_back(8'h00);
    for (int i = 0; i < 256; i++) sb.push_back(8'(i));
    sb.push_back(8'hA5);
    cyc(0, 1, 0);
    for (int c = 1; c <= 265; c++) cyc(0, 0, 0);
    chk("big_n_writes", n_wr, 32'd259);
    chk("big_first_wr", first_wr, 32'd1);
    chk("big_last_wr", last_wr, 32'd259);
    chk("big_done_cycle", done_cyc, 32'd260);
    chk("big_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
